// File: rtl/night_phase_pkg.sv
// Shared phase encoding, lane codes and helpers for the night-time lane sequencer.
package night_phase_pkg;

    typedef enum logic [2:0] {
        B_GO      = 3'd0,
        B_CLEAR   = 3'd1,
        A_GO      = 3'd2,
        A_CLEAR   = 3'd3,
        FLASH_ON  = 3'd4,
        FLASH_OFF = 3'd5
    } phase_t;

    typedef logic [1:0] lane_code_t;

    localparam lane_code_t GO   = 2'b11;
    localparam lane_code_t CLR  = 2'b01;
    localparam lane_code_t STOP = 2'b00;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/night_phase_sequencer_dwell_counter.sv
// Tick-driven dwell counter: counts advance strobes and flags the last tick of a dwell.
module dwell_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             advance,
    input  logic [CNT_W-1:0] dur,
    output logic             expire
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] count;

    assign expire = (count == dur - ONE);

    // NOTE: sequential state is written with <= only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            count <= '0;
        end else if (advance) begin
            count <= expire ? '0 : count + ONE;
        end
    end

endmodule

// File: rtl/night_phase_sequencer.sv
// Alternates lane groups A/B through timed go/clear phases, or flashes all lanes.
module night_phase_sequencer
    import night_phase_pkg::*;
#(
    parameter int NUM_LANES   = 4,
    parameter int GO_TICKS    = 8,
    parameter int CLEAR_TICKS = 2,
    parameter int FLASH_TICKS = 1,
    localparam int CNT_W      = $clog2(max3(GO_TICKS, CLEAR_TICKS, FLASH_TICKS)) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   tick_en,
    input  logic                   flash_mode,
    output logic [2*NUM_LANES-1:0] laneOutput,
    output logic [2:0]             phase,
    output logic                   phase_done
);

    // Lane 0 is group A (stop in B_GO), lane 1 is group B (go in B_GO), repeated.
    localparam logic [2*NUM_LANES-1:0] RESET_LANES = {(NUM_LANES/2){GO, STOP}};

    phase_t                 state;
    phase_t                 state_next;
    logic [CNT_W-1:0]       dur;
    logic                   bad_state;
    logic                   expire;
    logic                   commit;
    lane_code_t             code_a;
    lane_code_t             code_b;
    logic [2*NUM_LANES-1:0] lane_next;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        dur       = CNT_W'(GO_TICKS);
        bad_state = 1'b0;
        case (state)
            B_GO, A_GO:          dur = CNT_W'(GO_TICKS);
            B_CLEAR, A_CLEAR:    dur = CNT_W'(CLEAR_TICKS);
            FLASH_ON, FLASH_OFF: dur = CNT_W'(FLASH_TICKS);
            default:             bad_state = 1'b1;
        endcase
    end

    dwell_counter #(.CNT_W(CNT_W)) u_dwell (
        .clk     (clk),
        .rst     (rst),
        .clear   (bad_state),
        .advance (tick_en),
        .dur     (dur),
        .expire  (expire)
    );

    // The pulse marks the commit cycle itself, so it cannot be a registered copy.
    assign commit     = rst && tick_en && expire && !bad_state;
    assign phase_done = commit;

    // A GO always hands over to its CLEAR; flash is only entered from a CLEAR.
    always_comb begin
        state_next = state;
        case (state)
            B_GO:      if (commit) state_next = B_CLEAR;
            B_CLEAR:   if (commit) state_next = flash_mode ? FLASH_ON  : A_GO;
            A_GO:      if (commit) state_next = A_CLEAR;
            A_CLEAR:   if (commit) state_next = flash_mode ? FLASH_ON  : B_GO;
            FLASH_ON:  if (commit) state_next = flash_mode ? FLASH_OFF : B_GO;
            FLASH_OFF: if (commit) state_next = flash_mode ? FLASH_ON  : B_GO;
            default:   state_next = B_GO;
        endcase
    end

    always_comb begin
        code_a = STOP;
        code_b = STOP;
        case (state_next)
            B_GO:     code_b = GO;
            B_CLEAR:  code_b = CLR;
            A_GO:     code_a = GO;
            A_CLEAR:  code_a = CLR;
            FLASH_ON: begin
                code_a = CLR;
                code_b = CLR;
            end
            default: ;
        endcase
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        if (i % 2 == 0) begin : g_group_a
            assign lane_next[2*i +: 2] = code_a;
        end else begin : g_group_b
            assign lane_next[2*i +: 2] = code_b;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= B_GO;
            phase      <= B_GO;
            laneOutput <= RESET_LANES;
        end else begin
            state      <= state_next;
            phase      <= state_next;
            laneOutput <= lane_next;
        end
    end

endmodule

// File: tb/tb_night_phase_sequencer.sv
// Randomised and directed bench for night_phase_sequencer, 4-lane and 6-lane instances side by side.
module tb_night_phase_sequencer;
    import night_phase_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        tick_en;
    logic        flash_mode;
    logic [7:0]  lane4;
    logic [11:0] lane6;
    logic [2:0]  phase4, phase6;
    logic        done4, done6;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: current phase and ticks still owed before it ends.
    phase_t m_state;
    int     m_left;

    logic [7:0]  obs_lane4;
    logic [11:0] obs_lane6;
    logic [2:0]  obs_phase;
    logic        obs_done;
    logic [27:0] obs_all, exp_all;

    night_phase_sequencer #(.NUM_LANES(4), .GO_TICKS(3), .CLEAR_TICKS(1), .FLASH_TICKS(2)) dut4 (
        .clk(clk), .rst(rst), .tick_en(tick_en), .flash_mode(flash_mode),
        .laneOutput(lane4), .phase(phase4), .phase_done(done4)
    );

    night_phase_sequencer #(.NUM_LANES(6), .GO_TICKS(3), .CLEAR_TICKS(1), .FLASH_TICKS(2)) dut6 (
        .clk(clk), .rst(rst), .tick_en(tick_en), .flash_mode(flash_mode),
        .laneOutput(lane6), .phase(phase6), .phase_done(done6)
    );

    always #5 clk = ~clk;

    function automatic int dur_of(input phase_t s);
        case (s)
            B_GO, A_GO:       return 3;
            B_CLEAR, A_CLEAR: return 1;
            default:          return 2;
        endcase
    endfunction

    function automatic phase_t after(input phase_t s, input bit f);
        case (s)
            B_GO:     return B_CLEAR;
            A_GO:     return A_CLEAR;
            B_CLEAR:  return f ? FLASH_ON  : A_GO;
            A_CLEAR:  return f ? FLASH_ON  : B_GO;
            FLASH_ON: return f ? FLASH_OFF : B_GO;
            default:  return f ? FLASH_ON  : B_GO;
        endcase
    endfunction

    function automatic logic [11:0] lanes_of(input phase_t s, input int n);
        logic [11:0] r;
        logic [1:0]  ca, cb;
        r = '0;
        case (s)
            B_GO:     begin ca = 2'b00; cb = 2'b11; end
            B_CLEAR:  begin ca = 2'b00; cb = 2'b01; end
            A_GO:     begin ca = 2'b11; cb = 2'b00; end
            A_CLEAR:  begin ca = 2'b01; cb = 2'b00; end
            FLASH_ON: begin ca = 2'b01; cb = 2'b01; end
            default:  begin ca = 2'b00; cb = 2'b00; end
        endcase
        for (int i = 0; i < n; i++) r[2*i +: 2] = (i % 2 == 0) ? ca : cb;
        return r;
    endfunction

    // One clock: apply inputs, sample both DUTs and the model mid-cycle, then advance the model.
    task automatic drive(input bit r, input bit t, input bit f);
        logic [11:0] l4;
        logic        d;
        rst = r; tick_en = t; flash_mode = f;
        @(negedge clk);
        obs_lane4 = lane4; obs_lane6 = lane6; obs_phase = phase4; obs_done = done4;
        obs_all   = {lane4, lane6, phase4, phase6, done4, done6};
        l4        = lanes_of(m_state, 4);
        d         = r && t && (m_left == 1);
        exp_all   = {l4[7:0], lanes_of(m_state, 6), m_state, m_state, d, d};
        @(posedge clk);
        if (!r) begin
            m_state = B_GO;
            m_left  = dur_of(B_GO);
        end else if (t) begin
            if (m_left == 1) begin
                m_state = after(m_state, f);
                m_left  = dur_of(m_state);
            end else begin
                m_left--;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        logic [7:0] lane_tab [9] = '{8'hCC, 8'hCC, 8'hCC, 8'h44, 8'h33, 8'h33, 8'h33, 8'h11, 8'hCC};
        bit         done_tab [9] = '{0, 0, 1, 1, 0, 0, 1, 1, 0};
        drive(0, 1, 0);
        compared++;
        if (obs_all !== exp_all) begin
            mismatched++;
            $display("FAIL reset_hold: got %h expected %h", obs_all, exp_all);
        end
        for (int k = 0; k < 9; k++) begin
            drive(1, 1, 0);
            compared++;
            if (obs_all !== exp_all) begin
                mismatched++;
                $display("FAIL reset_seq_model cyc%0d: got %h expected %h", k, obs_all, exp_all);
            end
            compared++;
            if (obs_lane4 !== lane_tab[k] || obs_done !== done_tab[k]) begin
                mismatched++;
                $display("FAIL reset_seq_const cyc%0d: got lanes %b done %b expected lanes %b done %b",
                         k, obs_lane4, obs_done, lane_tab[k], done_tab[k]);
            end
        end
    endtask

    task automatic test_width();
        logic [11:0] tab [9] = '{12'hCCC, 12'hCCC, 12'hCCC, 12'h444, 12'h333, 12'h333, 12'h333, 12'h111, 12'hCCC};
        drive(0, 0, 0);
        for (int k = 0; k < 9; k++) begin
            drive(1, 1, 0);
            compared++;
            if (obs_lane6 !== tab[k] || obs_all !== exp_all) begin
                mismatched++;
                $display("FAIL width6 cyc%0d: got %b expected %b (all %h vs %h)", k, obs_lane6, tab[k], obs_all, exp_all);
            end
        end
    endtask

    task automatic test_tick_gating();
        int  bgo_len = 0;
        bit  in_bgo  = 1;
        drive(0, 0, 0);
        for (int k = 0; k < 12; k++) begin
            drive(1, (k % 3 == 2), 0);
            if (in_bgo && obs_phase == B_GO) bgo_len++;
            else in_bgo = 0;
            compared++;
            if (obs_all !== exp_all) begin
                mismatched++;
                $display("FAIL tick_gating cyc%0d: got %h expected %h", k, obs_all, exp_all);
            end
        end
        compared++;
        if (bgo_len !== 9) begin
            mismatched++;
            $display("FAIL tick_gating_len: got %0d cycles expected 9", bgo_len);
        end
    endtask

    task automatic test_flash_entry();
        logic [7:0] tab [14] = '{8'hCC, 8'hCC, 8'hCC, 8'h44, 8'h55, 8'h55, 8'h00,
                                 8'h00, 8'h55, 8'h55, 8'h00, 8'h00, 8'h55, 8'h55};
        drive(0, 0, 0);
        for (int k = 0; k < 14; k++) begin
            drive(1, 1, k >= 1);
            compared++;
            if (obs_lane4 !== tab[k] || obs_all !== exp_all) begin
                mismatched++;
                $display("FAIL flash_entry cyc%0d: got %b expected %b (all %h vs %h)", k, obs_lane4, tab[k], obs_all, exp_all);
            end
        end
    endtask

    task automatic test_flash_exit();
        int guard = 0;
        while (m_state != FLASH_OFF && guard < 10) begin
            drive(1, 1, 1);
            guard++;
        end
        compared++;
        if (m_state != FLASH_OFF) begin
            mismatched++;
            $display("FAIL flash_exit_setup: got model phase %0d expected %0d", m_state, FLASH_OFF);
        end
        for (int k = 0; k < 3; k++) begin
            drive(1, 1, 0);
            compared++;
            if (obs_all !== exp_all) begin
                mismatched++;
                $display("FAIL flash_exit cyc%0d: got %h expected %h", k, obs_all, exp_all);
            end
        end
        compared++;
        if (obs_lane4 !== 8'hCC || obs_phase !== B_GO) begin
            mismatched++;
            $display("FAIL flash_exit_bgo: got %b/%0d expected 11001100/%0d", obs_lane4, obs_phase, B_GO);
        end
    endtask

    task automatic test_mid_reset();
        logic [7:0] tab [4] = '{8'hCC, 8'hCC, 8'hCC, 8'h44};
        drive(0, 0, 0);
        for (int k = 0; k < 5; k++) drive(1, 1, 0);
        compared++;
        if (m_state != A_GO || m_left != 2) begin
            mismatched++;
            $display("FAIL mid_reset_setup: got model phase %0d left %0d expected %0d left 2", m_state, m_left, A_GO);
        end
        drive(0, 1, 0);
        compared++;
        if (obs_all !== exp_all || obs_done !== 1'b0) begin
            mismatched++;
            $display("FAIL mid_reset_edge: got %h expected %h", obs_all, exp_all);
        end
        for (int k = 0; k < 4; k++) begin
            drive(1, 1, 0);
            compared++;
            if (obs_lane4 !== tab[k] || obs_all !== exp_all) begin
                mismatched++;
                $display("FAIL mid_reset_after cyc%0d: got %b expected %b (all %h vs %h)", k, obs_lane4, tab[k], obs_all, exp_all);
            end
        end
    endtask

    task automatic test_random();
        bit f = 0;
        for (int k = 0; k < 500; k++) begin
            if ($urandom_range(0, 15) == 0) f = ~f;
            drive($urandom_range(0, 39) != 0, $urandom_range(0, 1) == 1, f);
            compared++;
            if (obs_all !== exp_all) begin
                mismatched++;
                $display("FAIL random cyc%0d: got %h expected %h", k, obs_all, exp_all);
            end
        end
    endtask

    initial begin
        rst = 1'b0; tick_en = 1'b0; flash_mode = 1'b0;
        @(posedge clk);
        #1;
        m_state = B_GO;
        m_left  = dur_of(B_GO);
        test_reset();
        test_width();
        test_tick_gating();
        test_flash_entry();
        test_flash_exit();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/night_phase_sequencer.md
Name: night_phase_sequencer

Overview:
- Parametrised successor to the fixed 8-bit night-time lane toggler. Drives a configurable number of lanes through timed go/clear phases, alternating between two lane groups, plus an all-lanes flash mode.
- Sits between the mode/timing controller, which supplies the prescaled `tick_en` and `flash_mode`, and the lamp driver, which consumes `laneOutput`.
- Phase dwell is counted in ticks, not raw clocks.

Parameters:
- NUM_LANES, 4, number of lanes; even, ≥2. Even-indexed lanes form group A (N,S); odd-indexed lanes form group B (E,W).
- GO_TICKS, 8, ticks spent in each GO phase; ≥1.
- CLEAR_TICKS, 2, ticks spent in each CLEAR phase; ≥1.
- FLASH_TICKS, 1, ticks per flash half-period; ≥1.
- CNT_W, $clog2(max of the three tick parameters)+1, width of the dwell counter; derived, not overridden.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
- tick_en  in  1  one-cycle prescaled strobe; the dwell counter advances only when it is 1.
- flash_mode  in  1  0 = alternate group A/group B; 1 = all-lane flash.
- laneOutput  out  2*NUM_LANES  per-lane code. Lane i occupies bits [2i+1:2i]. 11 = go, 01 = clear, 00 = stop.
- phase  out  3  current state encoding, see the package.
- phase_done  out  1  one-cycle pulse in the cycle where a state transition is committed.

Behaviour:
- States: B_GO, B_CLEAR, A_GO, A_CLEAR, FLASH_ON, FLASH_OFF.
- Outputs per state:
  - B_GO: group B = 11, group A = 00.
  - B_CLEAR: B = 01, A = 00.
  - A_GO: A = 11, B = 00.
  - A_CLEAR: A = 01, B = 00.
  - FLASH_ON: all lanes 01.
  - FLASH_OFF: all lanes 00.
- laneOutput and phase are registered, decoded from the state register. No combinational path from inputs to outputs.
- Reset (rst=0 at a clock edge):
  - state = B_GO, counter = 0, phase_done = 0.
  - With NUM_LANES=4, laneOutput = 8'b11001100.
  - Reset applies regardless of tick_en or flash_mode, including in mid-phase.
- Dwell counting:
  - When tick_en=1 and counter < DUR(state)-1, the counter increments.
  - When tick_en=1 and counter == DUR(state)-1, the transition commits: counter goes to 0 and phase_done=1 for that cycle. The new state is visible from the next cycle.
  - When tick_en=0, the counter holds and no transition occurs.
  - DUR(state) is GO_TICKS, CLEAR_TICKS or FLASH_TICKS as appropriate.
- Transitions, evaluated only at commit:
  - flash_mode=0: B_GO→B_CLEAR→A_GO→A_CLEAR→B_GO.
  - flash_mode=0 while in FLASH_ON or FLASH_OFF: next state is B_GO.
  - flash_mode=1: FLASH_ON↔FLASH_OFF.
  - flash_mode=1 while in any GO or CLEAR state: next state is FLASH_ON. The current phase completes its full dwell first; a GO never cuts directly to flash.
- flash_mode changes between commits have no effect until the next commit.
- Invalid state encoding: next edge goes to B_GO with counter 0.

Decomposition:
- Package `night_phase_pkg`:
  - state enum/localparams: B_GO=0, B_CLEAR=1, A_GO=2, A_CLEAR=3, FLASH_ON=4, FLASH_OFF=5.
  - lane codes: GO=2'b11, CLR=2'b01, STOP=2'b00.
- One natural sub-module: `dwell_counter`. It takes a load/advance strobe and a duration, and outputs `expire`.
- Lane mapping is a generate loop in the top module.

Test Plan:
All scenarios use NUM_LANES=4, GO=3, CLEAR=1, FLASH=2, with tick_en held at 1 unless stated.
1. Reset sequence:
   - Stimulus: rst=0 for 2 edges, then rst=1.
   - Response: laneOutput=11001100 for 3 cycles, then 01000100 for 1 cycle, then 00110011 for 3 cycles, then 00010001 for 1 cycle, then back to 11001100.
   - phase_done pulses in the last cycle of each phase.
2. Tick gating:
   - Stimulus: tick_en=1 every 3rd cycle.
   - Response: B_GO lasts 9 clocks; the counter holds between strobes.
3. Flash entry:
   - Stimulus: flash_mode=1 raised in cycle 1 of B_GO.
   - Response: B_GO and B_CLEAR complete unchanged, then 01010101 for 2 cycles, 00000000 for 2 cycles, and the flash alternation repeats.
4. Flash exit:
   - Stimulus: flash_mode=0 during FLASH_OFF.
   - Response: after FLASH_OFF's 2 cycles, laneOutput=11001100 (B_GO).
5. Mid-phase reset:
   - Stimulus: rst=0 for one edge during A_GO with counter=1.
   - Response: next cycle laneOutput=11001100 and the counter restarts; B_GO then lasts a full 3 cycles.
6. Width scaling:
   - Stimulus: NUM_LANES=6, reset released.
   - Response: laneOutput=12'b110011001100, followed by the same sequence as scenario 1 scaled to 6 lanes.
